// File: rtl/serial_paralelo.sv
// Serial-to-parallel lane receiver: samples one bit per clk_8f edge, locks byte
// alignment on a run of COMMA symbols, then presents each non-COMMA byte with a valid flag.
module serial_paralelo #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int          LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_ACTIVE
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT);

    state_t     state_q,   state_d;
    logic [7:0] sr_q,      sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bc_cnt_q,  bc_cnt_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;

    logic [7:0] w;
    logic       is_comma;
    logic       boundary;

    assign w        = {sr_q[6:0], serial_in};
    assign is_comma = (w == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        sr_d      = w;
        bit_cnt_d = boundary ? 3'd0 : bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;

        unique case (state_q)
            ST_SEARCH: begin
                valid_d = 1'b0;
                // Sliding match: any bit position may start a COMMA while searching.
                if (is_comma) begin
                    state_d   = ST_ALIGN;
                    bc_cnt_d  = 3'd1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_ALIGN: begin
                valid_d = 1'b0;
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                        if ({1'b0, bc_cnt_q} + 4'd1 == LOCK_LAST) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        state_d  = ST_SEARCH;
                        bc_cnt_d = 3'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    if (is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = w;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = (state_q == ST_ACTIVE);

endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Single-lane serial-to-parallel receiver for the PCIe-style physical link. It samples one serial bit per `clk_8f` cycle and locks byte alignment on a run of `COMMA` idle symbols. Once locked, it re-forms bytes and presents them with a valid flag at the `clk_8f` domain. One instance sits at the far end of each lane, opposite the parallel-to-serial transmitter, which sends `COMMA` whenever its `valid_in` is low.

## Interface
Parameters:
- `COMMA`, 8'hBC: idle/alignment symbol.
- `LOCK_COUNT`, 4: consecutive aligned `COMMA` bytes required to declare the link active (range 2–7).

Ports:
- `clk_8f`, input, 1: bit clock; all logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `serial_in`, input, 1: serial data, MSB first, one bit per `clk_8f` cycle.
- `data_out`, output, 8: last received non-`COMMA` byte.
- `valid_out`, output, 1: `data_out` holds a byte received in the current byte period.
- `active`, output, 1: byte alignment locked.

## Operation
- Shift register `sr[7:0] <= {sr[6:0], serial_in}` on every edge.
- Next word `w = {sr[6:0], serial_in}` is combinational.
- `bit_cnt` (3 b) counts bits of the current byte. A byte boundary is an edge where `bit_cnt == 7`; at that edge `bit_cnt <= 0`. On all other edges `bit_cnt` increments.
- `bc_cnt` (3 b) counts consecutive aligned `COMMA` bytes.

State machine: SEARCH, ALIGN, ACTIVE.
- **SEARCH**
  - `bit_cnt` is ignored.
  - Every edge, compare `w` with `COMMA` (bitwise sliding match).
  - On a match: `state <= ALIGN`, `bc_cnt <= 1`, `bit_cnt <= 0`.
- **ALIGN**
  - At each boundary where `w == COMMA`: `bc_cnt <= bc_cnt + 1`.
  - If `bc_cnt + 1 == LOCK_COUNT`: `state <= ACTIVE`, `active <= 1`.
  - At a boundary where `w != COMMA`: `state <= SEARCH`, `bc_cnt <= 0`. No sliding match is taken on that same edge.
- **ACTIVE**
  - At each boundary where `w != COMMA`: `data_out <= w`, `valid_out <= 1`.
  - At each boundary where `w == COMMA`: `valid_out <= 0`, `data_out` holds.
  - Between boundaries, `data_out` and `valid_out` hold.
  - ACTIVE is left only by reset. No loss-of-lock detection in this block.
- `active` is 0 in SEARCH and ALIGN, and 1 in ACTIVE.
- `valid_out` is 0 outside ACTIVE.

## Timing
- Reset (`reset == 0`, asynchronous, immediate):
  - State SEARCH; `sr`, `bit_cnt`, `bc_cnt` all 0.
  - `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
- Reset asserted mid-byte or mid-lock discards all partial state. After deassertion, the block re-searches from the next edge.
- Boundaries are spaced exactly 8 edges apart. The first boundary falls 8 edges after the SEARCH match edge.
- `active` rises on the boundary edge that completes the `LOCK_COUNT`-th `COMMA`. With default parameters and a clean stream, that is 24 edges after the first match.
- Data latency: `data_out`/`valid_out` update on the edge that samples the byte's 8th (LSB) bit. They remain stable for 8 edges.
- Back-to-back data bytes: `valid_out` stays 1 continuously, and `data_out` changes at each boundary.
- Spurious `COMMA` pattern straddling two bytes while in SEARCH: ALIGN rejects it at the next boundary, unless that boundary is also `COMMA`.
- All-zero or all-one stream: the block never leaves SEARCH.

## Test plan
- **Reset:** hold `reset = 0` for 10 cycles with a random `serial_in` -> `data_out = 00`, `valid_out = 0`, `active = 0` throughout.
- **Lock:** after reset, send 8'hBC ×4 MSB first, with 3 junk bits `101` in front -> `active` rises on the 32nd bit edge after the junk bits; `valid_out` stays 0.
- **Data:** locked, send FF, EE, DD, CC, then BC, BC -> `data_out` FF/EE/DD/CC at successive 8-edge boundaries with `valid_out = 1`. `valid_out` drops at the BC boundary while `data_out` holds CC.
- **Abort:** send BC, BC, then 8'h32 -> back to SEARCH at the 32 boundary; `active` stays 0; a subsequent 4×BC locks.
- **False match:** stream bits forming BC across a byte boundary (e.g. `..0B C4..` nibble-shifted), then non-BC data -> no lock.
- **Reset mid-operation:** locked, pull `reset` low at bit 3 of byte AA -> outputs clear immediately; after release, the lock requires 4 fresh BCs.
